fifo_unloader: RTL

Drain side of the transition-logger event FIFO. It watches the FIFO empty flag and pops one WIDTH-bit record at a time with a single-cycle unload pulse. It allows for the one-cycle read latency of the FIFO's dual-port RAM, captures the record, and serializes it MSB-byte-first onto a valid/ready byte stream toward the host link (UART/SPI framer).

---
 rtl/fifo_unloader.sv | 112 +++++++++++
 1 files changed

// File: rtl/fifo_unloader.sv
// Pops one record from the event FIFO and streams it MSB byte first; first byte 3 cycles after IDLE sees data.
// Backpressure: tx_ready low holds the current byte; new pops wait for the last byte to be accepted.
module fifo_unloader #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 6,
    parameter int CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             fifo_empty,
    input  logic [DEPTH-1:0] fifo_items,
    input  logic [WIDTH-1:0] fifo_dataout,
    output logic             fifo_unloaden,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             tx_sof,
    output logic             tx_last,
    output logic             busy,
    output logic [CNTW-1:0]  records_sent
);

    localparam int BYTES = WIDTH / 8;
    localparam int IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        CAP,
        SEND
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [IDXW-1:0]  idx;
    logic             start;
    logic [IDXW-1:0]  idx_nxt;

    // Occupancy is informational only; control relies on fifo_empty alone.
    logic unused_items;
    assign unused_items = ^fifo_items;

    assign start   = enable && !fifo_empty;
    assign idx_nxt = idx + 1'b1;
    assign tx_data = shreg[WIDTH-1 -: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            shreg         <= '0;
            idx           <= '0;
            fifo_unloaden <= 1'b0;
            tx_valid      <= 1'b0;
            tx_sof        <= 1'b0;
            tx_last       <= 1'b0;
            busy          <= 1'b0;
            records_sent  <= '0;
        end else begin
            fifo_unloaden <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state         <= POP;
                        fifo_unloaden <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                POP: begin
                    // RAM output becomes valid during the following cycle.
                    state <= CAP;
                end
                CAP: begin
                    shreg    <= fifo_dataout;
                    idx      <= '0;
                    tx_valid <= 1'b1;
                    tx_sof   <= 1'b1;
                    tx_last  <= (BYTES == 1);
                    state    <= SEND;
                end
                SEND: begin
                    if (tx_ready) begin
                        if (idx == LAST_IDX) begin
                            records_sent <= records_sent + CNTW'(1);
                            tx_valid     <= 1'b0;
                            tx_sof       <= 1'b0;
                            tx_last      <= 1'b0;
                            if (start) begin
                                state         <= POP;
                                fifo_unloaden <= 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            shreg   <= shreg << 8;
                            idx     <= idx_nxt;
                            tx_sof  <= 1'b0;
                            tx_last <= (idx_nxt == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
